// File: rtl/filter_accel_mul_pipe.sv
// Pipelined multiplier with per-beat signed modes, right shift, saturation and valid/ready flow control.
// Optional FILTER_ACCEL_MUL_PIPE_ROUND_EN: round half toward +inf before saturation instead of floor.
module filter_accel_mul_pipe #(
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 11,
    parameter int dout_WIDTH = 19,
    parameter int NUM_STAGE  = 3,
    parameter int SHIFT      = 0,
    parameter int OUT_SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din0_signed,
    input  logic                  din1_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW = din0_WIDTH + din1_WIDTH + 2;
`ifdef FILTER_ACCEL_MUL_PIPE_ROUND_EN
    localparam int RW = PW + 1;
    localparam logic [RW:0]          RND_X = (RW + 1)'(1) << SHIFT;
    localparam logic signed [RW-1:0] RND   = RND_X[RW:1];
`else
    localparam int RW = PW;
`endif
    // Compare width wide enough for both the shifted product and the unsigned upper bound.
    localparam int CW = (RW > dout_WIDTH + 2) ? RW : dout_WIDTH + 2;
    localparam logic signed [CW-1:0] ONE   = CW'(1);
    localparam logic signed [CW-1:0] MAX_V = (OUT_SIGNED != 0) ? (ONE <<< (dout_WIDTH - 1)) - ONE
                                                               : (ONE <<< dout_WIDTH) - ONE;
    localparam logic signed [CW-1:0] MIN_V = (OUT_SIGNED != 0) ? -(ONE <<< (dout_WIDTH - 1))
                                                               : CW'(0);

    logic signed [PW-1:0] a_x, b_x, prod;
    logic signed [RW-1:0] sum, shr;
    logic signed [CW-1:0] r_x;
    logic [dout_WIDTH-1:0] res_d;
    logic                  ovf_d;
    logic                  adv;

    logic                  valid_q [NUM_STAGE];
    logic [dout_WIDTH-1:0] dout_q  [NUM_STAGE];
    logic                  ovf_q   [NUM_STAGE];

    always_comb begin
        a_x = {{(PW - din0_WIDTH){din0_signed & din0[din0_WIDTH-1]}}, din0};
        b_x = {{(PW - din1_WIDTH){din1_signed & din1[din1_WIDTH-1]}}, din1};
        prod = a_x * b_x;
        sum = RW'(prod);
`ifdef FILTER_ACCEL_MUL_PIPE_ROUND_EN
        sum = sum + RND;
`endif
        shr = sum >>> SHIFT;
        r_x = CW'(shr);
        res_d = r_x[dout_WIDTH-1:0];
        ovf_d = 1'b0;
        if (r_x > MAX_V) begin
            res_d = MAX_V[dout_WIDTH-1:0];
            ovf_d = 1'b1;
        end else if (r_x < MIN_V) begin
            res_d = MIN_V[dout_WIDTH-1:0];
            ovf_d = 1'b1;
        end
    end

    assign out_valid = valid_q[NUM_STAGE-1];
    assign dout      = dout_q[NUM_STAGE-1];
    assign ovf       = ovf_q[NUM_STAGE-1];
    assign adv       = ce & (~out_valid | out_ready);
    assign in_ready  = adv;

    // With ce low the pipe is frozen, but a completed output handshake must still retire the beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                valid_q[i] <= 1'b0;
                dout_q[i]  <= '0;
                ovf_q[i]   <= 1'b0;
            end
        end else if (adv) begin
            valid_q[0] <= in_valid;
            dout_q[0]  <= res_d;
            ovf_q[0]   <= ovf_d;
            for (int i = 1; i < NUM_STAGE; i++) begin
                valid_q[i] <= valid_q[i-1];
                dout_q[i]  <= dout_q[i-1];
                ovf_q[i]   <= ovf_q[i-1];
            end
        end else if (out_valid && out_ready) begin
            valid_q[NUM_STAGE-1] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_filter_accel_mul_pipe.sv
// Bench for filter_accel_mul_pipe: several parameter sets driven in parallel, checked against
// an arithmetic reference with a per-instance expected-result queue and advance-cycle latency.
module tb_filter_accel_mul_pipe;

    localparam int NI = 6;
    localparam int NS_A [NI] = '{3, 3, 3, 3, 1, 8};
    localparam int OW_A [NI] = '{19, 19, 8, 19, 12, 4};
    localparam int SH_A [NI] = '{0, 0, 4, 2, 3, 19};
    localparam int OS_A [NI] = '{0, 1, 0, 1, 1, 1};

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, out_ready;
    logic [7:0]  din0;
    logic [10:0] din1;
    logic        din0_signed, din1_signed;

    logic        in_ready_a  [NI];
    logic        out_valid_a [NI];
    logic        ovf_a       [NI];
    logic [31:0] dout_a      [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [OW_A[g]-1:0] d;
        logic ir, ov, of;
        filter_accel_mul_pipe #(
            .din0_WIDTH(8), .din1_WIDTH(11), .dout_WIDTH(OW_A[g]),
            .NUM_STAGE(NS_A[g]), .SHIFT(SH_A[g]), .OUT_SIGNED(OS_A[g])
        ) u_dut (
            .clk(clk), .reset(reset), .ce(ce),
            .in_valid(in_valid), .in_ready(ir),
            .din0(din0), .din1(din1),
            .din0_signed(din0_signed), .din1_signed(din1_signed),
            .out_valid(ov), .out_ready(out_ready),
            .dout(d), .ovf(of)
        );
        assign in_ready_a[g]  = ir;
        assign out_valid_a[g] = ov;
        assign ovf_a[g]       = of;
        assign dout_a[g]      = 32'(d);
    end

    typedef struct {
        logic [31:0] d;
        bit          o;
        int          stamp;
    } exp_t;

    exp_t        q [NI][$];
    int          adv_cnt [NI];
    bit          seen [NI];
    logic [31:0] cap0 [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic void model(input int k, input logic [7:0] a, input logic [10:0] b,
                                  input bit sa, input bit sb,
                                  output logic [31:0] d, output bit o);
        longint ea, eb, p, r, hi, lo;
        ea = sa ? longint'($signed(a)) : longint'(a);
        eb = sb ? longint'($signed(b)) : longint'(b);
        p = ea * eb;
`ifdef FILTER_ACCEL_MUL_PIPE_ROUND_EN
        if (SH_A[k] > 0) p = p + (longint'(1) << (SH_A[k] - 1));
`endif
        r = p >>> SH_A[k];
        if (OS_A[k] != 0) begin
            hi = (longint'(1) << (OW_A[k] - 1)) - 1;
            lo = -(longint'(1) << (OW_A[k] - 1));
        end else begin
            hi = (longint'(1) << OW_A[k]) - 1;
            lo = 0;
        end
        o = 1'b0;
        if (r > hi) begin r = hi; o = 1'b1; end
        else if (r < lo) begin r = lo; o = 1'b1; end
        d = 32'(r & ((longint'(1) << OW_A[k]) - 1));
    endfunction

    // Per-cycle compare and scoreboard update; inputs are stable from here to the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < NI; k++) begin
                q[k].delete();
                seen[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                logic adv;
                exp_t e;
                chk($sformatf("in_ready[%0d]", k), 32'(in_ready_a[k]),
                    32'(ce & (~out_valid_a[k] | out_ready)));
                if (out_valid_a[k] === 1'b1) begin
                    checks++;
                    if (q[k].size() == 0) begin
                        errors++;
                        $display("FAIL spurious_out[%0d] got dout=%0h expected no beat", k, dout_a[k]);
                    end else begin
                        if (!seen[k]) begin
                            chk($sformatf("latency[%0d]", k), 32'(adv_cnt[k] - q[k][0].stamp),
                                32'(NS_A[k]));
                            seen[k] = 1'b1;
                        end
                        chk($sformatf("dout[%0d]", k), dout_a[k], q[k][0].d);
                        chk($sformatf("ovf[%0d]", k), 32'(ovf_a[k]), 32'(q[k][0].o));
                    end
                end else if (q[k].size() > 0) begin
                    chk($sformatf("overdue[%0d]", k),
                        32'(q[k][0].stamp + NS_A[k] <= adv_cnt[k]), 32'(0));
                end
                adv = ce & (~out_valid_a[k] | out_ready);
                if (out_valid_a[k] && out_ready && q[k].size() > 0) begin
                    if (k == 0) cap0.push_back(dout_a[0]);
                    void'(q[k].pop_front());
                    seen[k] = 1'b0;
                end
                if (in_valid && in_ready_a[k]) begin
                    model(k, din0, din1, din0_signed, din1_signed, e.d, e.o);
                    e.stamp = adv_cnt[k];
                    q[k].push_back(e);
                end
                if (adv) adv_cnt[k]++;
            end
        end
    end

    logic [31:0] gd [NI];
    logic        go [NI];
    int          gl [NI];
    bit          got [NI];

    // One beat into an empty pipe; records each instance's first output and its latency.
    task automatic beat(input logic [7:0] a, input logic [10:0] b, input bit sa, input bit sb);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; din0 = a; din1 = b; din0_signed = sa; din1_signed = sb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < NI; k++) got[k] = 1'b0;
        n = 1;
        repeat (20) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++)
                if (!got[k] && out_valid_a[k]) begin
                    got[k] = 1'b1; gd[k] = dout_a[k]; go[k] = ovf_a[k]; gl[k] = n;
                end
            @(posedge clk); #1;
            n++;
        end
        for (int k = 0; k < NI; k++)
            if (!got[k]) begin
                checks++; errors++;
                $display("FAIL beat_timeout[%0d] got no out_valid expected one within 20 cycles", k);
            end
    endtask

    // 10 back-to-back beats into instance 0; mode 0 blocks out_ready, mode 1 drops ce.
    task automatic stream(input int mode);
        int idx, c;
        cap0.delete();
        idx = 1;
        c = 0;
        while (idx <= 10 && c < 200) begin
            @(posedge clk); #1;
            out_ready = (mode == 0) ? !(c >= 5 && c <= 8) : 1'b1;
            ce = (mode == 1) ? !(c == 4 || c == 5) : 1'b1;
            in_valid = 1'b1; din0 = 8'(idx); din1 = 11'd3; din0_signed = 1'b0; din1_signed = 1'b0;
            @(negedge clk);
            if (in_ready_a[0]) idx++;
            c++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; ce = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk($sformatf("stream%0d_count", mode), 32'(cap0.size()), 32'd10);
        for (int i = 0; i < cap0.size() && i < 10; i++)
            chk($sformatf("stream%0d_val%0d", mode, i), cap0[i], 32'(3 * (i + 1)));
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        din0 = '0; din1 = '0; din0_signed = 1'b0; din1_signed = 1'b0;
        for (int k = 0; k < NI; k++) adv_cnt[k] = 0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_valid[%0d]", k), 32'(out_valid_a[k]), 32'd0);
            chk($sformatf("rst_dout[%0d]", k), dout_a[k], 32'd0);
            chk($sformatf("rst_ovf[%0d]", k), 32'(ovf_a[k]), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        beat(8'd255, 11'd2047, 1'b0, 1'b0);
        chk("d_255x2047", gd[0], 32'd521985);
        chk("o_255x2047", 32'(go[0]), 32'd0);
        for (int k = 0; k < NI; k++)
            chk($sformatf("lat_beat[%0d]", k), 32'(gl[k]), 32'(NS_A[k]));

        beat(8'h80, 11'd1023, 1'b1, 1'b0);
        chk("d_m128x1023_s", gd[1], 32'h60080);
        chk("o_m128x1023_s", 32'(go[1]), 32'd0);
        chk("d_m128x1023_u", gd[0], 32'd0);
        chk("o_m128x1023_u", 32'(go[0]), 32'd1);

        beat(8'h80, 11'h7FF, 1'b1, 1'b1);
        chk("d_m128xm1", gd[1], 32'd128);

        beat(8'hFF, 11'd5, 1'b1, 1'b0);
        chk("d_m1x5_u", gd[0], 32'd0);
        chk("o_m1x5_u", 32'(go[0]), 32'd1);

        beat(8'd200, 11'd100, 1'b0, 1'b0);
        chk("d_200x100_w8s4", gd[2], 32'd255);
        chk("o_200x100_w8s4", 32'(go[2]), 32'd1);

        beat(8'd3, 11'd2, 1'b0, 1'b0);
`ifdef FILTER_ACCEL_MUL_PIPE_ROUND_EN
        chk("d_3x2_s2", gd[3], 32'd2);
`else
        chk("d_3x2_s2", gd[3], 32'd1);
`endif

        beat(8'hFD, 11'd2, 1'b1, 1'b0);
`ifdef FILTER_ACCEL_MUL_PIPE_ROUND_EN
        chk("d_m3x2_s2", gd[3], 32'h7FFFF);
`else
        chk("d_m3x2_s2", gd[3], 32'h7FFFE);
`endif

        stream(0);
        stream(1);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid    = ($urandom_range(0, 9) < 7);
            din0        = 8'($urandom);
            din1        = 11'($urandom);
            din0_signed = 1'($urandom);
            din1_signed = 1'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            ce          = ($urandom_range(0, 9) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; ce = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++)
            chk($sformatf("drained[%0d]", k), 32'(q[k].size()), 32'd0);

        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; din0 = 8'd4; din1 = 11'd4; din0_signed = 1'b0; din1_signed = 1'b0;
        @(posedge clk); #1;
        din0 = 8'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_valid0", 32'(out_valid_a[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("async_rst_valid[%0d]", k), 32'(out_valid_a[k]), 32'd0);
            chk($sformatf("async_rst_dout[%0d]", k), dout_a[k], 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        cap0.delete();
        beat(8'd7, 11'd7, 1'b0, 1'b0);
        chk("post_rst_d", gd[0], 32'd49);
        chk("post_rst_count", 32'(cap0.size()), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
